// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared opcodes, control-word layout and MulDiv FSM state for ctrl_pipeline.
// Optional M-extension support is controlled by the CTRL_MULDIV_EN macro.
package ctrl_pkg;

  // RV32I major opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // control-word bit positions
  localparam int C_ALUSRC   = 7;
  localparam int C_MEMTOREG = 6;
  localparam int C_REGWRITE = 5;
  localparam int C_MEMREAD  = 4;
  localparam int C_MEMWRITE = 3;
  localparam int C_BRANCH   = 2;
  localparam int C_JUMP     = 1;
  localparam int C_MULDIV   = 0;

  typedef logic [7:0] ctrl_t;

  // single-bit masks so decode reads as a sum of named fields
  localparam ctrl_t CW_ALUSRC   = ctrl_t'(1) << C_ALUSRC;
  localparam ctrl_t CW_MEMTOREG = ctrl_t'(1) << C_MEMTOREG;
  localparam ctrl_t CW_REGWRITE = ctrl_t'(1) << C_REGWRITE;
  localparam ctrl_t CW_MEMREAD  = ctrl_t'(1) << C_MEMREAD;
  localparam ctrl_t CW_MEMWRITE = ctrl_t'(1) << C_MEMWRITE;
  localparam ctrl_t CW_BRANCH   = ctrl_t'(1) << C_BRANCH;
  localparam ctrl_t CW_JUMP     = ctrl_t'(1) << C_JUMP;
  localparam ctrl_t CW_MULDIV   = ctrl_t'(1) << C_MULDIV;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational ID-stage decode of one instruction into a control
// word, destination register and source-use flags.
// MulDiv decode only exists when CTRL_MULDIV_EN is defined.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int INST_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [INST_WIDTH-1:0]     inst,
  input  logic                      id_valid,
  output ctrl_t                     ctrl,
  output logic [REG_ADDR_WIDTH-1:0] rd,
  output logic [REG_ADDR_WIDTH-1:0] rs1,
  output logic [REG_ADDR_WIDTH-1:0] rs2,
  output logic                      rs1_used,
  output logic                      rs2_used,
  output logic                      illegal,
  output logic                      is_div
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  assign rs1    = inst[15 +: REG_ADDR_WIDTH];
  assign rs2    = inst[20 +: REG_ADDR_WIDTH];

  // rd only matters to hazard and writeback logic when the op writes back
  assign rd = ctrl[C_REGWRITE] ? inst[7 +: REG_ADDR_WIDTH] : '0;

  // not every instruction bit feeds decode in every build
  logic unused_inst;
  assign unused_inst = ^{inst, funct3, funct7};

  // opcode decode; an invalid ID slot decodes as an all-zero bubble
  always_comb begin
    ctrl     = '0;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    illegal  = 1'b0;
    is_div   = 1'b0;
    if (id_valid) begin
      case (opcode)
        OP_R: begin
          ctrl     = CW_REGWRITE;
          rs1_used = 1'b1;
          rs2_used = 1'b1;
`ifdef CTRL_MULDIV_EN
          if (funct7 == F7_MULDIV) begin
            ctrl   = CW_REGWRITE | CW_MULDIV;
            is_div = funct3[2];
          end
`endif
        end
        OP_IALU: begin
          ctrl     = CW_ALUSRC | CW_REGWRITE;
          rs1_used = 1'b1;
        end
        OP_LUI, OP_AUIPC: ctrl = CW_ALUSRC | CW_REGWRITE;
        OP_LOAD: begin
          ctrl     = CW_ALUSRC | CW_MEMTOREG | CW_REGWRITE | CW_MEMREAD;
          rs1_used = 1'b1;
        end
        OP_STORE: begin
          ctrl     = CW_ALUSRC | CW_MEMWRITE;
          rs1_used = 1'b1;
          rs2_used = 1'b1;
        end
        OP_BRANCH: begin
          ctrl     = CW_BRANCH;
          rs1_used = 1'b1;
          rs2_used = 1'b1;
        end
        OP_JAL: ctrl = CW_REGWRITE | CW_BRANCH | CW_JUMP;
        OP_JALR: begin
          ctrl     = CW_ALUSRC | CW_REGWRITE | CW_JUMP;
          rs1_used = 1'b1;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline: five-stage pipeline control unit. Decodes ID, carries the
// control word through ID/EX, EX/MEM, MEM/WB, generates load-use stall and
// bubbles, and (with CTRL_MULDIV_EN defined) holds EX for multi-cycle MulDiv.
module ctrl_pipeline
  import ctrl_pkg::*;
#(
  parameter int INST_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MUL_LATENCY    = 2,
  parameter int DIV_LATENCY    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [INST_WIDTH-1:0]     inst,
  input  logic                      id_valid,
  input  logic                      flush,
  input  logic                      hold,
  output logic                      stall,
  output ctrl_t                     ex_ctrl,
  output ctrl_t                     mem_ctrl,
  output ctrl_t                     wb_ctrl,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic [REG_ADDR_WIDTH-1:0] mem_rd,
  output logic [REG_ADDR_WIDTH-1:0] wb_rd,
  output logic                      ex_illegal
);

  ctrl_t                     d_ctrl;
  logic [REG_ADDR_WIDTH-1:0] d_rd, d_rs1, d_rs2;
  logic                      d_rs1_used, d_rs2_used, d_illegal, d_is_div;

  ctrl_decode #(
    .INST_WIDTH    (INST_WIDTH),
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_dec (
    .inst    (inst),
    .id_valid(id_valid),
    .ctrl    (d_ctrl),
    .rd      (d_rd),
    .rs1     (d_rs1),
    .rs2     (d_rs2),
    .rs1_used(d_rs1_used),
    .rs2_used(d_rs2_used),
    .illegal (d_illegal),
    .is_div  (d_is_div)
  );

  logic load_use, md_busy;

  // x0 is never a real producer, so an rd of 0 can't create a hazard
  assign load_use = ex_ctrl[C_MEMREAD] && (ex_rd != '0) &&
                    ((d_rs1_used && (d_rs1 == ex_rd)) ||
                     (d_rs2_used && (d_rs2 == ex_rd)));

  // stall stays live under flush; IF/ID is being killed so it is harmless
  assign stall = load_use | md_busy;

`ifdef CTRL_MULDIV_EN
  localparam int MAX_LAT = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
  localparam int CW      = $clog2(MAX_LAT + 1);

  md_state_t     md_state;
  logic [CW-1:0] md_cnt, md_lat;
  logic          ex_is_div, md_start;

  assign md_lat   = ex_is_div ? CW'(DIV_LATENCY) : CW'(MUL_LATENCY);
  // first EX cycle of a multi-cycle op already counts toward its latency
  assign md_start = (md_state == MD_IDLE) && ex_ctrl[C_MULDIV] && (md_lat > CW'(1));
  assign md_busy  = md_start || ((md_state == MD_BUSY) && (md_cnt != '0));

  // MulDiv occupancy FSM: counter holds the EX cycles left after the next one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_state <= MD_IDLE;
      md_cnt   <= '0;
    end else if (!hold) begin
      if (flush) begin
        md_state <= MD_IDLE;
        md_cnt   <= '0;
      end else begin
        case (md_state)
          MD_IDLE: if (md_start) begin
            md_state <= MD_BUSY;
            md_cnt   <= md_lat - CW'(2);
          end
          MD_BUSY: if (md_cnt == '0) md_state <= MD_IDLE;
                   else              md_cnt   <= md_cnt - CW'(1);
          default: md_state <= MD_IDLE;
        endcase
      end
    end
  end

  // DIV/MUL selector rides alongside the EX control word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     ex_is_div <= 1'b0;
    else if (!hold) begin
      if (flush)                    ex_is_div <= 1'b0;
      else if (md_busy)             ex_is_div <= ex_is_div;
      else if (load_use)            ex_is_div <= 1'b0;
      else                          ex_is_div <= d_is_div;
    end
  end
`else
  logic unused_is_div;
  assign unused_is_div = d_is_div;
  assign md_busy       = 1'b0;
`endif

  // stage registers: hold > flush > MulDiv busy > load-use > normal shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ctrl    <= '0;
      ex_rd      <= '0;
      ex_illegal <= 1'b0;
      mem_ctrl   <= '0;
      mem_rd     <= '0;
      wb_ctrl    <= '0;
      wb_rd      <= '0;
    end else if (!hold) begin
      wb_ctrl <= mem_ctrl;
      wb_rd   <= mem_rd;
      if (md_busy && !flush) begin
        // EX keeps the long op; a bubble drains into MEM behind it
        mem_ctrl <= '0;
        mem_rd   <= '0;
      end else begin
        mem_ctrl <= ex_ctrl;
        mem_rd   <= ex_rd;
        if (flush || load_use) begin
          ex_ctrl    <= '0;
          ex_rd      <= '0;
          ex_illegal <= 1'b0;
        end else begin
          ex_ctrl    <= d_ctrl;
          ex_rd      <= d_rd;
          ex_illegal <= d_illegal;
        end
      end
    end
  end

endmodule

// File: tb/tb_ctrl_pipeline.sv
// tb_ctrl_pipeline: table-driven scoreboard bench for ctrl_pipeline.
// MulDiv sequences follow the CTRL_MULDIV_EN build of the design.
module tb_ctrl_pipeline;

  logic        clk = 1'b0;
  logic        rst_n, id_valid, flush, hold;
  logic [31:0] inst;
  logic        stall, ex_illegal;
  logic [7:0]  ex_ctrl, mem_ctrl, wb_ctrl;
  logic [4:0]  ex_rd, mem_rd, wb_rd;

  always #5 clk = ~clk;

  ctrl_pipeline dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .id_valid(id_valid),
    .flush(flush), .hold(hold), .stall(stall),
    .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd), .ex_illegal(ex_illegal)
  );

  typedef struct {
    logic [31:0] inst;
    logic        v, fl, hd, st;
    logic [7:0]  exc;
    logic [4:0]  exr;
    logic        exi;
    logic [7:0]  mc;
    logic [4:0]  mr;
    logic [7:0]  wc;
    logic [4:0]  wr;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[26];
  int   errs = 0, checks = 0;

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [4:0] r2,
                                     input logic [4:0] r1, input logic [2:0] f3,
                                     input logic [4:0] rd, input logic [6:0] op);
    return {f7, r2, r1, f3, rd, op};
  endfunction

  function automatic vec_t mkv(input logic [31:0] i, input logic v, fl, hd, st,
                               input logic [7:0] exc, input logic [4:0] exr, input logic exi,
                               input logic [7:0] mc, input logic [4:0] mr,
                               input logic [7:0] wc, input logic [4:0] wr);
    vec_t r;
    r.inst = i; r.v = v; r.fl = fl; r.hd = hd; r.st = st;
    r.exc = exc; r.exr = exr; r.exi = exi; r.mc = mc; r.mr = mr; r.wc = wc; r.wr = wr;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // drive one cycle, check combinational stall, then check registers after the edge
  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    @(negedge clk);
    inst = v.inst; id_valid = v.v; flush = v.fl; hold = v.hd;
    sb.push_back(v);
    #1 chk({tag, " stall"}, 32'(stall), 32'(v.st));
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, " ex_ctrl"},    32'(ex_ctrl),    32'(e.exc));
    chk({tag, " ex_rd"},      32'(ex_rd),      32'(e.exr));
    chk({tag, " ex_illegal"}, 32'(ex_illegal), 32'(e.exi));
    chk({tag, " mem_ctrl"},   32'(mem_ctrl),   32'(e.mc));
    chk({tag, " mem_rd"},     32'(mem_rd),     32'(e.mr));
    chk({tag, " wb_ctrl"},    32'(wb_ctrl),    32'(e.wc));
    chk({tag, " wb_rd"},      32'(wb_rd),      32'(e.wr));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " stall"},      32'(stall),      32'h0);
    chk({tag, " ex_ctrl"},    32'(ex_ctrl),    32'h0);
    chk({tag, " ex_rd"},      32'(ex_rd),      32'h0);
    chk({tag, " ex_illegal"}, 32'(ex_illegal), 32'h0);
    chk({tag, " mem_ctrl"},   32'(mem_ctrl),   32'h0);
    chk({tag, " mem_rd"},     32'(mem_rd),     32'h0);
    chk({tag, " wb_ctrl"},    32'(wb_ctrl),    32'h0);
    chk({tag, " wb_rd"},      32'(wb_rd),      32'h0);
  endtask

  initial begin
    logic [31:0] lw5, lw0, add651, add600, lui5, jal1, nop, ill, sw5, beq, jalr, div7, mul8;
    lw5    = mk(7'd0, 5'd0, 5'd1, 3'd2, 5'd5, 7'b0000011);
    lw0    = mk(7'd0, 5'd0, 5'd1, 3'd2, 5'd0, 7'b0000011);
    add651 = mk(7'd0, 5'd1, 5'd5, 3'd0, 5'd6, 7'b0110011);
    add600 = mk(7'd0, 5'd0, 5'd0, 3'd0, 5'd6, 7'b0110011);
    lui5   = mk(7'd0, 5'd5, 5'd5, 3'd0, 5'd5, 7'b0110111);
    jal1   = mk(7'd0, 5'd0, 5'd0, 3'd0, 5'd1, 7'b1101111);
    nop    = mk(7'd0, 5'd0, 5'd0, 3'd0, 5'd0, 7'b0010011);
    ill    = mk(7'd0, 5'd0, 5'd0, 3'd0, 5'd3, 7'b1111111);
    sw5    = mk(7'd0, 5'd5, 5'd1, 3'd2, 5'd0, 7'b0100011);
    beq    = mk(7'd0, 5'd5, 5'd1, 3'd0, 5'd0, 7'b1100011);
    jalr   = mk(7'd0, 5'd0, 5'd5, 3'd0, 5'd1, 7'b1100111);
    div7   = mk(7'd1, 5'd2, 5'd3, 3'd4, 5'd7, 7'b0110011);
    mul8   = mk(7'd1, 5'd2, 5'd3, 3'd0, 5'd8, 7'b0110011);

    //             inst    v  fl hd st  exc    exr  exi mc     mr    wc     wr
    tbl[0]  = mkv(lw5,    1, 0, 0, 0, 8'hF0, 5'd5, 0, 8'h00, 5'd0, 8'h00, 5'd0);
    tbl[1]  = mkv(add651, 1, 0, 0, 1, 8'h00, 5'd0, 0, 8'hF0, 5'd5, 8'h00, 5'd0);
    tbl[2]  = mkv(add651, 1, 0, 0, 0, 8'h20, 5'd6, 0, 8'h00, 5'd0, 8'hF0, 5'd5);
    tbl[3]  = mkv(lw0,    1, 0, 0, 0, 8'hF0, 5'd0, 0, 8'h20, 5'd6, 8'h00, 5'd0);
    tbl[4]  = mkv(add600, 1, 0, 0, 0, 8'h20, 5'd6, 0, 8'hF0, 5'd0, 8'h20, 5'd6);
    tbl[5]  = mkv(lw5,    1, 0, 0, 0, 8'hF0, 5'd5, 0, 8'h20, 5'd6, 8'hF0, 5'd0);
    tbl[6]  = mkv(lui5,   1, 0, 0, 0, 8'hA0, 5'd5, 0, 8'hF0, 5'd5, 8'h20, 5'd6);
    tbl[7]  = mkv(jal1,   1, 0, 0, 0, 8'h26, 5'd1, 0, 8'hA0, 5'd5, 8'hF0, 5'd5);
    tbl[8]  = mkv(nop,    1, 1, 0, 0, 8'h00, 5'd0, 0, 8'h26, 5'd1, 8'hA0, 5'd5);
    tbl[9]  = mkv(ill,    1, 0, 0, 0, 8'h00, 5'd0, 1, 8'h00, 5'd0, 8'h26, 5'd1);
    tbl[10] = mkv(add651, 0, 0, 0, 0, 8'h00, 5'd0, 0, 8'h00, 5'd0, 8'h00, 5'd0);
    tbl[11] = mkv(lw5,    1, 0, 0, 0, 8'hF0, 5'd5, 0, 8'h00, 5'd0, 8'h00, 5'd0);
    tbl[12] = mkv(add651, 1, 0, 1, 1, 8'hF0, 5'd5, 0, 8'h00, 5'd0, 8'h00, 5'd0);
    tbl[13] = mkv(add651, 1, 0, 1, 1, 8'hF0, 5'd5, 0, 8'h00, 5'd0, 8'h00, 5'd0);
    tbl[14] = mkv(add651, 1, 0, 1, 1, 8'hF0, 5'd5, 0, 8'h00, 5'd0, 8'h00, 5'd0);
    tbl[15] = mkv(add651, 1, 0, 0, 1, 8'h00, 5'd0, 0, 8'hF0, 5'd5, 8'h00, 5'd0);
    tbl[16] = mkv(add651, 1, 0, 0, 0, 8'h20, 5'd6, 0, 8'h00, 5'd0, 8'hF0, 5'd5);
    tbl[17] = mkv(lw5,    1, 0, 0, 0, 8'hF0, 5'd5, 0, 8'h20, 5'd6, 8'h00, 5'd0);
    tbl[18] = mkv(add651, 1, 1, 0, 1, 8'h00, 5'd0, 0, 8'hF0, 5'd5, 8'h20, 5'd6);
    tbl[19] = mkv(nop,    1, 0, 0, 0, 8'hA0, 5'd0, 0, 8'h00, 5'd0, 8'hF0, 5'd5);
    tbl[20] = mkv(lw5,    1, 0, 0, 0, 8'hF0, 5'd5, 0, 8'hA0, 5'd0, 8'h00, 5'd0);
    tbl[21] = mkv(sw5,    1, 0, 0, 1, 8'h00, 5'd0, 0, 8'hF0, 5'd5, 8'hA0, 5'd0);
    tbl[22] = mkv(sw5,    1, 0, 0, 0, 8'h88, 5'd0, 0, 8'h00, 5'd0, 8'hF0, 5'd5);
    tbl[23] = mkv(beq,    1, 0, 0, 0, 8'h04, 5'd0, 0, 8'h88, 5'd0, 8'h00, 5'd0);
    tbl[24] = mkv(jalr,   1, 0, 0, 0, 8'hA2, 5'd1, 0, 8'h04, 5'd0, 8'h88, 5'd0);
    tbl[25] = mkv(nop,    1, 0, 0, 0, 8'hA0, 5'd0, 0, 8'hA2, 5'd1, 8'h04, 5'd0);

    rst_n = 1'b0; inst = '0; id_valid = 1'b0; flush = 1'b0; hold = 1'b0;
    #12 chk_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    // make the pipe non-empty, then reset asynchronously mid-cycle
    apply(mkv(lw5,    1, 0, 0, 0, 8'hF0, 5'd5, 0, 8'h00, 5'd0, 8'h00, 5'd0), "pre0");
    apply(mkv(add651, 1, 0, 0, 1, 8'h00, 5'd0, 0, 8'hF0, 5'd5, 8'h00, 5'd0), "pre1");
    @(negedge clk);
    inst = lw5; id_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    inst = '0; id_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 26; i++) apply(tbl[i], $sformatf("row%0d", i));

`ifdef CTRL_MULDIV_EN
    // div (latency 8): stall for 7 cycles, leaves EX on the 8th
    apply(mkv(div7, 1, 0, 0, 0, 8'h21, 5'd7, 0, 8'hA0, 5'd0, 8'hA2, 5'd1), "div0");
    for (int i = 1; i <= 7; i++)
      apply(mkv(nop, 1, 0, 0, 1, 8'h21, 5'd7, 0, 8'h00, 5'd0,
                (i == 1) ? 8'hA0 : 8'h00, 5'd0), $sformatf("div%0d", i));
    apply(mkv(nop, 1, 0, 0, 0, 8'hA0, 5'd0, 0, 8'h21, 5'd7, 8'h00, 5'd0), "div8");
    apply(mkv(nop, 1, 0, 0, 0, 8'hA0, 5'd0, 0, 8'hA0, 5'd0, 8'h21, 5'd7), "div9");
    // flush on the third busy cycle returns the FSM to idle at once
    apply(mkv(div7, 1, 0, 0, 0, 8'h21, 5'd7, 0, 8'hA0, 5'd0, 8'hA0, 5'd0), "dfl0");
    apply(mkv(nop,  1, 0, 0, 1, 8'h21, 5'd7, 0, 8'h00, 5'd0, 8'hA0, 5'd0), "dfl1");
    apply(mkv(nop,  1, 0, 0, 1, 8'h21, 5'd7, 0, 8'h00, 5'd0, 8'h00, 5'd0), "dfl2");
    apply(mkv(nop,  1, 1, 0, 1, 8'h00, 5'd0, 0, 8'h21, 5'd7, 8'h00, 5'd0), "dfl3");
    apply(mkv(nop,  1, 0, 0, 0, 8'hA0, 5'd0, 0, 8'h00, 5'd0, 8'h21, 5'd7), "dfl4");
    // mul (latency 2): a single stall cycle
    apply(mkv(mul8, 1, 0, 0, 0, 8'h21, 5'd8, 0, 8'hA0, 5'd0, 8'h00, 5'd0), "mul0");
    apply(mkv(nop,  1, 0, 0, 1, 8'h21, 5'd8, 0, 8'h00, 5'd0, 8'hA0, 5'd0), "mul1");
    apply(mkv(nop,  1, 0, 0, 0, 8'hA0, 5'd0, 0, 8'h21, 5'd8, 8'h00, 5'd0), "mul2");
    // hold during busy freezes the counter: still 8 non-hold EX cycles
    apply(mkv(div7, 1, 0, 0, 0, 8'h21, 5'd7, 0, 8'hA0, 5'd0, 8'h21, 5'd8), "dh0");
    apply(mkv(nop,  1, 0, 0, 1, 8'h21, 5'd7, 0, 8'h00, 5'd0, 8'hA0, 5'd0), "dh1");
    apply(mkv(nop,  1, 0, 1, 1, 8'h21, 5'd7, 0, 8'h00, 5'd0, 8'hA0, 5'd0), "dh_hold_a");
    apply(mkv(nop,  1, 0, 1, 1, 8'h21, 5'd7, 0, 8'h00, 5'd0, 8'hA0, 5'd0), "dh_hold_b");
    for (int i = 2; i <= 7; i++)
      apply(mkv(nop, 1, 0, 0, 1, 8'h21, 5'd7, 0, 8'h00, 5'd0, 8'h00, 5'd0), $sformatf("dh%0d", i));
    apply(mkv(nop,  1, 0, 0, 0, 8'hA0, 5'd0, 0, 8'h21, 5'd7, 8'h00, 5'd0), "dh8");
`else
    // without MulDiv support, funct7=0000001 is a plain R-type
    apply(mkv(div7, 1, 0, 0, 0, 8'h20, 5'd7, 0, 8'hA0, 5'd0, 8'hA2, 5'd1), "rdiv0");
    apply(mkv(nop,  1, 0, 0, 0, 8'hA0, 5'd0, 0, 8'h20, 5'd7, 8'hA0, 5'd0), "rdiv1");
    apply(mkv(mul8, 1, 0, 0, 0, 8'h20, 5'd8, 0, 8'hA0, 5'd0, 8'h20, 5'd7), "rmul0");
    apply(mkv(nop,  1, 0, 0, 0, 8'hA0, 5'd0, 0, 8'h20, 5'd8, 8'hA0, 5'd0), "rmul1");
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/ctrl_pipeline.md
# ctrl_pipeline

Parametrised control unit for the five-stage RV32I pipeline. Decodes the ID-stage instruction into an 8-bit control word and carries it through ID/EX, EX/MEM and MEM/WB registers. It generates the load-use stall, inserts bubbles on stall or branch flush, and optionally holds EX for multi-cycle M-extension operations. It sits between the IF/ID register and the datapath stage registers, and replaces the purely combinational ID control decode.

## Interface
Parameters:
- INST_WIDTH, 32, instruction width
- REG_ADDR_WIDTH, 5, register index width
- MUL_LATENCY, 2, EX cycles for MUL* (≥1)
- DIV_LATENCY, 8, EX cycles for DIV*/REM* (≥1)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- inst  in  INST_WIDTH  instruction in ID
- id_valid  in  1  ID holds a real instruction
- flush  in  1  taken branch/jump resolved in EX; kill ID
- hold  in  1  external freeze (memory wait) of all stage registers
- stall  out  1  freeze PC and IF/ID
- ex_ctrl, mem_ctrl, wb_ctrl  out  8 each  registered control word per stage
- ex_rd, mem_rd, wb_rd  out  REG_ADDR_WIDTH each  destination register per stage
- ex_illegal  out  1  registered illegal-opcode flag

## Operation
- Control word bits [7:0]: {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, MulDiv}.
- Decode by opcode:
  - R 0110011 → RegWrite; with funct7=0000001 also MulDiv.
  - I-ALU 0010011, LUI 0110111, AUIPC 0010111 → ALUSrc, RegWrite.
  - Load 0000011 → ALUSrc, MemtoReg, RegWrite, MemRead.
  - Store 0100011 → ALUSrc, MemWrite.
  - Branch 1100011 → Branch.
  - JAL 1101111 → RegWrite, Branch, Jump.
  - JALR 1100111 → ALUSrc, RegWrite, Jump.
  - Any other opcode → 0 with illegal=1.
  - id_valid=0 → word 0, illegal 0.
- rs1 is used by R, I-ALU, load, store, branch and JALR. rs2 is used by R, store and branch.
- Load-use: stall=1 when ex_ctrl.MemRead, ex_rd≠0, and ex_rd matches a used rs1/rs2 of a valid ID instruction.
- Bubble means word 0, rd 0, illegal 0.
- Per-cycle update priority:
  1. hold: every register keeps its value.
  2. flush: EX loads a bubble; the busy counter clears; MEM/WB advance normally.
  3. MulDiv busy: EX keeps its value, MEM loads a bubble, WB advances, stall=1.
  4. Load-use: EX loads a bubble, MEM/WB advance, stall=1.
  5. Otherwise all three stages shift: decode→EX→MEM→WB.
- rd is forced to 0 when the decoded RegWrite=0.
- MulDiv FSM states: IDLE, BUSY.
  - IDLE → BUSY when EX holds a MulDiv op with latency >1. Counter loads latency−2. funct3[2]=1 selects DIV_LATENCY, else MUL_LATENCY.
  - BUSY: stall=1. The counter decrements each non-hold cycle. At 0 it returns to IDLE and EX advances that cycle.
  - Latency 1 never enters BUSY.

## Timing
- Decode→EX latency is 1 cycle. The word then reaches MEM after 2 cycles and WB after 3, absent stalls.
- stall is combinational from inst and the EX registers (plus FSM state). It is never registered.
- Reset (async, rst_n=0): all ctrl/rd/illegal outputs 0, FSM IDLE, counter 0, stall 0. Release is sampled on the clk edge.
- Reset mid-BUSY aborts the operation immediately.
- flush and load-use in the same cycle: flush wins, and stall still reflects the load-use compare. This is harmless because IF/ID is being flushed.
- hold during BUSY freezes the counter.
- A MulDiv op N cycles long occupies EX for exactly N non-hold cycles.

## Configuration
- CTRL_MULDIV_EN defined: MulDiv decode, FSM and counter are present.
- Undefined: funct7=0000001 decodes as plain R with MulDiv=0, the FSM is absent, and stall comes from load-use only. MUL_LATENCY and DIV_LATENCY are ignored.

## Structure
- Package ctrl_pkg holds:
  - opcode constants;
  - control-bit index constants;
  - the 8-bit ctrl_t word typedef;
  - the FSM state typedef.
- Sub-module ctrl_decode: combinational inst→{ctrl word, rd, rs1_used, rs2_used, illegal, is_div}. The top holds the stage registers, hazard logic and FSM.

## Test plan
- Reset: hold rst_n=0 mid-stream → all outputs 0 asynchronously. After release, lw x5 in ID → ex_ctrl=8'b11110000, ex_rd=5 next cycle.
- Load-use: lw x5 then add x6,x5,x1 → stall=1 for one cycle, ex_ctrl=0 that cycle, add reaches EX one cycle later.
- No false hazard: lw x0 then add x6,x0,x0; and lw x5 then lui x5 → stall stays 0.
- Flush: jal x1 in EX with flush=1 → EX bubble next cycle, the jal word reaches mem_ctrl=8'b00100110.
- MulDiv (macro on, DIV_LATENCY=8): div in EX → stall=1 for 7 cycles, mem_ctrl=0 for those cycles, div in mem_ctrl on cycle 8. Flush on cycle 3 → IDLE immediately.
- Illegal and hold: opcode 1111111 → ex_illegal=1 and ex_ctrl=0. hold=1 for 3 cycles → all outputs unchanged.
